// File: rtl/wbtimer.sv
// wbtimer: Wishbone-classic machine timer.
// 64-bit mtime advanced by a programmable prescaler, 64-bit mtimecmp, and a
// level interrupt while mtime >= mtimecmp. 32-bit word registers with
// byte-lane writes; MTIME_HI reads come from a shadow latched by MTIME_LO reads
// so a LO-then-HI pair is always a consistent 64-bit sample.
module wbtimer #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int PW = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_ack_o,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            irq_o
);

  typedef enum logic [2:0] {
    R_MTIME_LO = 3'd0,
    R_MTIME_HI = 3'd1,
    R_CMP_LO   = 3'd2,
    R_CMP_HI   = 3'd3,
    R_CTRL     = 3'd4,
    R_PRESCALE = 3'd5,
    R_STATUS   = 3'd6,
    R_NONE     = 3'd7
  } reg_e;

  logic [63:0]   mtime, mtimecmp;
  logic [31:0]   hi_shadow;
  logic          en, ie;
  logic [PW-1:0] prescale, prs, prescale_nxt;
  logic [DW-1:0] lane_mask, rdata, prs_merged;
  logic          req, wr, rd, tick, pend;
  reg_e          addr;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] val,
                                          input logic [DW-1:0] mask);
    return (old & ~mask) | (val & mask);
  endfunction

  // expand byte selects into a bit mask
  for (genvar i = 0; i < DW/8; i++) begin : g_lane
    assign lane_mask[8*i +: 8] = {8{wb_sel_i[i]}};
  end

  assign addr = reg_e'(wb_adr_i[2:0]);
  // a request is one strobe not already being acked this cycle
  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr   = req & wb_we_i;
  assign rd   = req & ~wb_we_i;
  assign tick = en & (prs == '0);
  assign pend = (mtime >= mtimecmp);

  assign prs_merged   = merge(DW'(prescale), wb_dat_i, lane_mask);
  assign prescale_nxt = (wr && addr == R_PRESCALE) ? prs_merged[PW-1:0] : prescale;

  logic unused;
  assign unused = &{1'b0, wb_adr_i[AW-1:3], prs_merged[DW-1:PW]};

  // read data mux
  always_comb begin
    rdata = '0;
    case (addr)
      R_MTIME_LO: rdata = mtime[31:0];
      R_MTIME_HI: rdata = hi_shadow;
      R_CMP_LO:   rdata = mtimecmp[31:0];
      R_CMP_HI:   rdata = mtimecmp[63:32];
      R_CTRL:     rdata = DW'({ie, en});
      R_PRESCALE: rdata = DW'(prescale);
      R_STATUS:   rdata = DW'(pend);
      default:    rdata = '0;
    endcase
  end

  // mtime: bus writes win over the tick increment on the same edge
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      mtime <= '0;
    end else if (wr && addr == R_MTIME_LO) begin
      mtime[31:0] <= merge(mtime[31:0], wb_dat_i, lane_mask);
    end else if (wr && addr == R_MTIME_HI) begin
      mtime[63:32] <= merge(mtime[63:32], wb_dat_i, lane_mask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp, control and prescale registers
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      mtimecmp <= '1;
      en       <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr && addr == R_CMP_LO) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wb_dat_i, lane_mask);
      if (wr && addr == R_CMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], wb_dat_i, lane_mask);
      if (wr && addr == R_CTRL && wb_sel_i[0]) {ie, en} <= wb_dat_i[1:0];
      prescale <= prescale_nxt;
    end
  end

  // prescaler down-counter; CTRL/PRESCALE writes restart the period
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      prs <= '0;
    end else if (wr && (addr == R_CTRL || addr == R_PRESCALE)) begin
      prs <= prescale_nxt;
    end else if (!en || prs == '0) begin
      prs <= prescale;
    end else begin
      prs <= prs - PW'(1);
    end
  end

  // bus response: one-cycle ack, read data and the MTIME_HI shadow
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      hi_shadow <= '0;
    end else begin
      wb_ack_o <= req;
      if (rd) begin
        wb_dat_o <= rdata;
        if (addr == R_MTIME_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

  // level interrupt from the registered compare
  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) irq_o <= 1'b0;
    else            irq_o <= ie & pend;
  end

endmodule
